// File: rtl/micore_pkg.sv
// Shared definitions for the micore instruction-memory path: loader FSM
// state encoding, the canonical NOP, and the default memory address width.
package micore_pkg;

  // Default byte-address width of the instruction memory (1 KiB).
  localparam int ADDR_W_DEFAULT = 10;

  // addi x0, x0, 0 -- what an unprogrammed instruction slot should hold.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } loader_state_e;

  // Running XOR checksum over the payload bytes.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot-time instruction-memory programmer. Receives a length-prefixed,
// XOR-checksummed byte frame, packs little-endian 32-bit words and writes
// them to the instruction memory while holding the core in reset.
// The word index is kept 16 bits wide to match the frame's length field,
// which limits ADDR_W to at most 18.
module imem_loader
  import micore_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

  // Word capacity, one bit wider than the length field so 65536 fits.
  localparam logic [16:0] WORDS = 17'd1 << (ADDR_W - 2);

  loader_state_e     state_r;
  logic [15:0]       len_r;
  logic [15:0]       word_idx_r;
  logic [1:0]        byte_cnt_r;
  logic [23:0]       asm_r;
  logic [7:0]        csum_r;
  logic              we_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [31:0]       wdata_r;
  logic              done_r;
  logic              error_r;

  logic              fire_s;
  logic [15:0]       len_next_s;
  logic              len_bad_s;
  logic              ready_s;
  logic              hold_s;

  assign fire_s     = s_valid && ready_s;
  assign len_next_s = {s_data, len_r[7:0]};
  assign len_bad_s  = (len_next_s == 16'd0) || ({1'b0, len_next_s} > WORDS);

  // Handshake readiness and core hold are pure decodes of the current state.
  always_comb begin
    ready_s = 1'b0;
    hold_s  = 1'b0;
    case (state_r)
      IDLE: begin
        ready_s = 1'b0;
        hold_s  = 1'b0;
      end
      LEN_LO, LEN_HI, DATA, CHECK: begin
        ready_s = 1'b1;
        hold_s  = 1'b1;
      end
      DONE: begin
        ready_s = 1'b0;
        hold_s  = 1'b0;
      end
      ERR: begin
        ready_s = 1'b0;
        hold_s  = 1'b1;
      end
      default: begin
        ready_s = 1'b0;
        hold_s  = 1'b0;
      end
    endcase
  end

  // Frame parser: length capture, word assembly, memory writes, checksum verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      len_r      <= 16'd0;
      word_idx_r <= 16'd0;
      byte_cnt_r <= 2'd0;
      asm_r      <= 24'd0;
      csum_r     <= 8'd0;
      we_r       <= 1'b0;
      waddr_r    <= '0;
      wdata_r    <= 32'd0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      we_r   <= 1'b0;
      done_r <= 1'b0;
      case (state_r)
        IDLE, ERR: begin
          // A new load may begin from rest or to recover from a failed load.
          if (start) begin
            state_r    <= LEN_LO;
            csum_r     <= 8'd0;
            word_idx_r <= 16'd0;
            byte_cnt_r <= 2'd0;
            error_r    <= 1'b0;
          end
        end
        LEN_LO: begin
          if (fire_s) begin
            len_r[7:0] <= s_data;
            state_r    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (fire_s) begin
            len_r[15:8] <= s_data;
            if (len_bad_s) begin
              state_r <= ERR;
              error_r <= 1'b1;
            end else begin
              state_r <= DATA;
            end
          end
        end
        DATA: begin
          if (fire_s) begin
            csum_r     <= csum_step(csum_r, s_data);
            byte_cnt_r <= byte_cnt_r + 2'd1;
            // Earlier bytes drift toward bit 0, so byte 0 lands in wdata[7:0].
            asm_r      <= {s_data, asm_r[23:8]};
            if (byte_cnt_r == 2'd3) begin
              we_r    <= 1'b1;
              waddr_r <= {word_idx_r[ADDR_W-3:0], 2'b00};
              wdata_r <= {s_data, asm_r};
              if (word_idx_r == (len_r - 16'd1)) begin
                state_r <= CHECK;
              end else begin
                word_idx_r <= word_idx_r + 16'd1;
              end
            end
          end
        end
        CHECK: begin
          if (fire_s) begin
            if (s_data == csum_r) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ERR;
              error_r <= 1'b1;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign s_ready   = ready_s;
  assign core_hold = hold_s;
  assign we        = we_r;
  assign waddr     = waddr_r;
  assign wdata     = wdata_r;
  assign done      = done_r;
  assign error     = error_r;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader. A frame-level reference
// model predicts the list of memory writes and the final verdict of each load.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        we;
  logic [9:0]  waddr;
  logic [31:0] wdata;
  logic        core_hold;
  logic        done;
  logic        error;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]  payload_q[$];
  logic [9:0]  obs_addr[$];
  logic [31:0] obs_data[$];
  int          done_cnt;
  int          hold_at_done;

  imem_loader #(.ADDR_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .core_hold (core_hold),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write pulse and done pulse seen by the memory side.
  always @(negedge clk) begin
    if (we) begin
      obs_addr.push_back(waddr);
      obs_data.push_back(wdata);
    end
    if (done) begin
      done_cnt++;
      if (core_hold) hold_at_done++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
    done_cnt     = 0;
    hold_at_done = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max, output bit ok);
    repeat ($urandom_range(gap_max, 0)) begin
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = b;
    ok      = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    s_valid = 1'b0;
    if (!ok) check("byte_timeout", 32'd0, 32'd1);
  endtask

  // Drive one complete frame built from payload_q and compare against the model.
  task automatic run_frame(input logic [15:0] n, input bit bad_csum,
                           input int gap_max, input int start_at);
    logic [7:0]  bytes[$];
    logic [7:0]  x;
    logic [31:0] exp_data[$];
    logic [9:0]  exp_addr[$];
    bit          len_bad;
    bit          exp_err;
    bit          ok;
    int          m;

    len_bad = (n == 16'd0) || (n > 16'd256);
    x = 8'd0;
    foreach (payload_q[i]) x = x ^ payload_q[i];
    bytes.push_back(n[7:0]);
    bytes.push_back(n[15:8]);
    if (!len_bad) begin
      foreach (payload_q[i]) bytes.push_back(payload_q[i]);
      bytes.push_back(bad_csum ? (x ^ 8'h5A) : x);
      for (int i = 0; i < int'(n); i++) begin
        exp_data.push_back({payload_q[4*i+3], payload_q[4*i+2], payload_q[4*i+1], payload_q[4*i]});
        exp_addr.push_back(10'(i * 4));
      end
    end
    exp_err = len_bad || bad_csum;

    clear_obs();
    pulse_start();
    check("start_clears_error", {31'd0, error}, 32'd0);
    check("len_lo_ready", {31'd0, s_ready}, 32'd1);

    foreach (bytes[i]) begin
      if (i == start_at) pulse_start();
      send_byte(bytes[i], gap_max, ok);
      if (!ok) break;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end

    check("write_count", obs_addr.size(), exp_addr.size());
    m = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < m; i++) begin
      check("waddr", {22'd0, obs_addr[i]}, {22'd0, exp_addr[i]});
      check("wdata", obs_data[i], exp_data[i]);
    end
    check("done_pulses", done_cnt, exp_err ? 32'd0 : 32'd1);
    check("hold_during_done", hold_at_done, 32'd0);
    check("error_flag", {31'd0, error}, {31'd0, exp_err});
    check("core_hold_after", {31'd0, core_hold}, {31'd0, exp_err});
    check("s_ready_after", {31'd0, s_ready}, 32'd0);
  endtask

  task automatic fill_random(input int nbytes);
    payload_q.delete();
    for (int i = 0; i < nbytes; i++) payload_q.push_back(8'($urandom_range(255, 0)));
  endtask

  initial begin
    logic [7:0] nominal[$];
    logic [31:0] first_word;
    bit ok;

    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'd0;
    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_waddr", {22'd0, waddr}, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_core_hold", {31'd0, core_hold}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    rst = 1'b0;

    // Bytes offered while idle must not be taken.
    s_valid = 1'b1; s_data = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_no_ready", {31'd0, s_ready}, 32'd0);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;

    // Nominal two-word image, without and with source gaps.
    nominal = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    payload_q = nominal;
    run_frame(16'd2, 1'b0, 0, -1);
    payload_q = nominal;
    run_frame(16'd2, 1'b0, 3, -1);

    // Bad checksum, then recovery straight from the error state.
    payload_q = nominal;
    run_frame(16'd2, 1'b1, 0, -1);
    payload_q = nominal;
    run_frame(16'd2, 1'b0, 1, -1);

    // Length bounds.
    payload_q.delete();
    run_frame(16'd0, 1'b0, 0, -1);
    payload_q.delete();
    run_frame(16'd257, 1'b0, 0, -1);
    fill_random(1024);
    run_frame(16'd256, 1'b0, 0, -1);

    // Start pulsed in the middle of the payload is ignored.
    fill_random(12);
    run_frame(16'd3, 1'b0, 1, 7);

    // Random frames.
    for (int k = 0; k < 10; k++) begin
      int n;
      n = $urandom_range(8, 1);
      fill_random(4 * n);
      run_frame(16'(n), ($urandom_range(3, 0) == 0), $urandom_range(3, 0), -1);
    end

    // Reset after five payload bytes of a four-word frame.
    clear_obs();
    fill_random(16);
    pulse_start();
    send_byte(8'd4, 0, ok);
    send_byte(8'd0, 0, ok);
    for (int i = 0; i < 5; i++) send_byte(payload_q[i], 1, ok);
    first_word = {payload_q[3], payload_q[2], payload_q[1], payload_q[0]};
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_we", {31'd0, we}, 32'd0);
    check("midrst_core_hold", {31'd0, core_hold}, 32'd0);
    check("midrst_error", {31'd0, error}, 32'd0);
    check("midrst_s_ready", {31'd0, s_ready}, 32'd0);
    check("midrst_writes", obs_data.size(), 32'd1);
    if (obs_data.size() > 0) check("midrst_word0", obs_data[0], first_word);
    fill_random(12);
    run_frame(16'd3, 1'b0, 2, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
